cpu6_instenc: RTL and testbench

RV32I instruction encoder for the cpu6 debug/test injection path: accepts field-level commands (class, rd, rs1, rs2, funct3, alt, imm), range-checks them, packs legal ones into 32-bit RV32I words, buffers them in a small FIFO and streams them to the fetch-injection port. It is the inverse of `cpu6_controller` decode: every word it emits decodes there to the commanded operation. A two-word `LI` pseudo-op expands to `lui`/`addi`.

---
 rtl/cpu6_instenc.sv | 195 +++++++++++++++++++
 tb/tb_cpu6_instenc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_instenc.sv
// RV32I field-command encoder with LI expansion feeding a small output FIFO for fetch injection.
// Latency: accepted word is at the FIFO head one cycle after the accept edge; LI word2 follows at the next edge at the earliest.
// Backpressure: in_ready drops when the FIFO is full or while LI word2 waits; FIFO pops on out_valid & out_ready.
module cpu6_instenc #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_cls,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic                     in_alt,
  input  logic [31:0]              in_imm,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_EMIT2 = 1'b1;

  localparam logic [2:0] CLS_OPIMM  = 3'd0;
  localparam logic [2:0] CLS_OP     = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JAL    = 3'd5;
  localparam logic [2:0] CLS_LUI    = 3'd6;

  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_LUI    = 7'h37;

  logic [0:0]        state;
  logic [31:0]       word2_q;
  logic [31:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              illegal;
  logic [31:0]       push_dat;
  logic [31:0]       enc_w1;
  logic [31:0]       enc_w2;
  logic              enc_two;
  logic              bad_f3;
  logic              bad_imm;
  logic signed [31:0] imm_s;
  logic              imm_i12;
  logic [19:0]       li_hi;

  assign imm_s   = in_imm;
  assign imm_i12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
  // Upper part for lui+addi: adding 0x800 only carries into bit 12 when imm[11] is set.
  assign li_hi   = in_imm[31:12] + {19'd0, in_imm[11]};

  assign full      = (count == (AW+1)'(DEPTH));
  assign in_ready  = resetn && !flush && (state == S_IDLE) && !full;
  assign accept    = in_valid && in_ready;
  assign illegal   = bad_f3 || bad_imm;
  assign pop       = out_valid && out_ready;
  assign push      = (state == S_IDLE) ? (accept && !illegal) : !full;
  assign push_dat  = (state == S_IDLE) ? enc_w1 : word2_q;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? mem[rd_ptr] : 32'd0;

  // Encode the presented command and classify it; funct3/alt faults outrank immediate faults.
  always_comb begin
    enc_w1  = 32'd0;
    enc_w2  = 32'd0;
    enc_two = 1'b0;
    bad_f3  = 1'b0;
    bad_imm = 1'b0;
    case (in_cls)
      CLS_OPIMM: begin
        if (in_funct3 == 3'd1 || in_funct3 == 3'd5) begin
          bad_f3  = in_alt && (in_funct3 != 3'd5);
          bad_imm = (imm_s < 32'sd0) || (imm_s > 32'sd31);
          enc_w1  = {1'b0, in_alt, 5'd0, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
        end else begin
          bad_f3  = in_alt;
          bad_imm = !imm_i12;
          enc_w1  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
        end
      end
      CLS_OP: begin
        bad_f3 = in_alt && !(in_funct3 == 3'd0 || in_funct3 == 3'd5);
        enc_w1 = {1'b0, in_alt, 5'd0, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
      end
      CLS_LOAD: begin
        bad_f3  = (in_funct3 == 3'd3) || (in_funct3 == 3'd6) || (in_funct3 == 3'd7);
        bad_imm = !imm_i12;
        enc_w1  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
      end
      CLS_STORE: begin
        bad_f3  = (in_funct3 > 3'd2);
        bad_imm = !imm_i12;
        enc_w1  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
      end
      CLS_BRANCH: begin
        bad_f3  = (in_funct3 == 3'd2) || (in_funct3 == 3'd3);
        bad_imm = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
        enc_w1  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      CLS_JAL: begin
        bad_imm = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
        enc_w1  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      CLS_LUI: begin
        bad_imm = (in_imm[11:0] != 12'd0);
        enc_w1  = {in_imm[31:12], in_rd, OPC_LUI};
      end
      default: begin
        // LI: short form is addi rd,x0,imm; long form is lui then an optional addi rd,rd,lo.
        if (imm_i12) begin
          enc_w1 = {in_imm[11:0], 5'd0, 3'd0, in_rd, OPC_OPIMM};
        end else begin
          enc_w1  = {li_hi, in_rd, OPC_LUI};
          enc_two = (in_imm[11:0] != 12'd0);
          enc_w2  = {in_imm[11:0], in_rd, 3'd0, in_rd, OPC_OPIMM};
        end
      end
    endcase
  end

  // Control FSM: IDLE accepts commands, EMIT2 parks the LI second word until there is room.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      state   <= S_IDLE;
      word2_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && !illegal && enc_two) begin
            word2_q <= enc_w2;
            state   <= S_EMIT2;
          end
        end
        default: begin
          if (!full) state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage; contents need no reset since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Error reporting: one-cycle pulse per rejected command, code held until the next rejection.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      err <= accept && illegal;
      if (accept && illegal) err_code <= bad_f3 ? 2'd2 : 2'd1;
    end
  end

endmodule

// File: tb/tb_cpu6_instenc.sv
// Self-checking bench for cpu6_instenc: directed commands, reference encoder model, popped-word scoreboard.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected words come from an arithmetic reference encoder, itself pinned by hand-computed literals.
module tb_cpu6_instenc;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, in_alt, out_valid, out_ready, err;
  logic [2:0]  in_cls, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm, out_instr;
  logic [1:0]  err_code;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  cpu6_instenc #(.DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_alt(in_alt), .in_imm(in_imm),
    .out_valid(out_valid), .out_instr(out_instr), .out_ready(out_ready),
    .err(err), .err_code(err_code), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder built from field arithmetic; nw = words produced, ec = error code (0 = legal).
  function automatic void ref_enc(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                                  input logic [31:0] u, output int nw, output logic [31:0] w1,
                                  output logic [31:0] w2, output int ec);
    int si;
    logic [31:0] r, s1, s2, f, a;
    si = $signed(u);
    r = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2); f = 32'(f3); a = 32'(alt);
    nw = 1; w1 = 0; w2 = 0; ec = 0;
    case (cls)
      3'd0: begin
        if (f == 1 || f == 5) begin
          if (alt && f != 5) ec = 2; else if (si < 0 || si > 31) ec = 1;
          w1 = (a << 30) | ((u & 31) << 20) | (s1 << 15) | (f << 12) | (r << 7) | 32'h13;
        end else begin
          if (alt) ec = 2; else if (si < -2048 || si > 2047) ec = 1;
          w1 = ((u & 32'hFFF) << 20) | (s1 << 15) | (f << 12) | (r << 7) | 32'h13;
        end
      end
      3'd1: begin
        if (alt && !(f == 0 || f == 5)) ec = 2;
        w1 = (a << 30) | (s2 << 20) | (s1 << 15) | (f << 12) | (r << 7) | 32'h33;
      end
      3'd2: begin
        if (!(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) ec = 2;
        else if (si < -2048 || si > 2047) ec = 1;
        w1 = ((u & 32'hFFF) << 20) | (s1 << 15) | (f << 12) | (r << 7) | 32'h03;
      end
      3'd3: begin
        if (f > 2) ec = 2; else if (si < -2048 || si > 2047) ec = 1;
        w1 = (((u >> 5) & 127) << 25) | (s2 << 20) | (s1 << 15) | (f << 12) | ((u & 31) << 7) | 32'h23;
      end
      3'd4: begin
        if (f == 2 || f == 3) ec = 2; else if ((si % 2) != 0 || si < -4096 || si > 4094) ec = 1;
        w1 = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (s2 << 20) | (s1 << 15) | (f << 12)
           | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
      end
      3'd5: begin
        if ((si % 2) != 0 || si < -1048576 || si > 1048574) ec = 1;
        w1 = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
           | (((u >> 12) & 255) << 12) | (r << 7) | 32'h6F;
      end
      3'd6: begin
        if ((u & 32'hFFF) != 0) ec = 1;
        w1 = (u & 32'hFFFFF000) | (r << 7) | 32'h37;
      end
      default: begin
        if (si >= -2048 && si <= 2047) begin
          w1 = ((u & 32'hFFF) << 20) | (r << 7) | 32'h13;
        end else begin
          w1 = ((u + 32'h800) & 32'hFFFFF000) | (r << 7) | 32'h37;
          if ((u & 32'hFFF) != 0) begin
            nw = 2;
            w2 = ((u & 32'hFFF) << 20) | (r << 15) | (r << 7) | 32'h13;
          end
        end
      end
    endcase
    if (ec != 0) nw = 0;
  endfunction

  // Scoreboard: every word the consumer takes must be the next word the model expects.
  always @(negedge clk) begin
    if (resetn && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got 0x%08h, expected no word", out_instr);
      end else begin
        chk("pop_word", out_instr, exp_q.pop_front());
      end
    end
  end

  // Present one command, wait (bounded) for acceptance, update the model, check the error response.
  task automatic send(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic alt, input logic [31:0] imm);
    int nw, ec;
    logic [31:0] w1, w2;
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    in_cls = cls; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_alt = alt; in_imm = imm;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      in_valid = 1'b0;
      chk("accept_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    ref_enc(cls, rd, rs1, rs2, f3, alt, imm, nw, w1, w2, ec);
    if (nw >= 1) exp_q.push_back(w1);
    if (nw == 2) exp_q.push_back(w2);
    @(negedge clk);
    chk("err_pulse", 32'(err), 32'(ec != 0));
    if (ec != 0) chk("err_code", 32'(err_code), 32'(ec));
  endtask

  // Let the consumer pop until the FIFO and model are both empty (bounded), then stall it again.
  task automatic drain();
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!out_valid && exp_q.size() == 0) begin ok = 1; break; end
    end
    chk("drain_done", 32'(ok), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int nw, ec;
    logic [31:0] w1, w2;

    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_cls = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_alt = 1'b0; in_imm = 32'd0;

    // Pin the reference model with hand-computed encodings.
    ref_enc(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, nw, w1, w2, ec);
    chk("pin_addi", w1, 32'h00500093);
    ref_enc(3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, nw, w1, w2, ec);
    chk("pin_sub", w1, 32'h402081B3);
    ref_enc(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF, nw, w1, w2, ec);
    chk("pin_li_w1", w1, 32'h123462B7);
    chk("pin_li_w2", w2, 32'hFFF28293);
    chk("pin_li_nw", 32'(nw), 32'd2);
    ref_enc(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, nw, w1, w2, ec);
    chk("pin_beq", w1, 32'h00208463);
    ref_enc(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd7, nw, w1, w2, ec);
    chk("pin_beq_odd_ec", 32'(ec), 32'd1);
    ref_enc(3'd3, 5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'd0, nw, w1, w2, ec);
    chk("pin_store_f3_ec", 32'(ec), 32'd2);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // addi then sub, held at the head while the consumer stalls.
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    chk("addi_head", out_instr, 32'h00500093);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_count", 32'(count), 32'd1);
    send(3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    chk("sub_count", 32'(count), 32'd2);
    chk("sub_head_stable", out_instr, 32'h00500093);
    drain();

    // Two-word LI costs one in_ready bubble.
    send(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
    chk("li_w1_head", out_instr, 32'h123462B7);
    chk("li_bubble", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("li_ready_back", 32'(in_ready), 32'd1);
    chk("li_count2", 32'(count), 32'd2);
    drain();

    // LI with zero low bits is a single lui.
    send(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000);
    chk("li1_head", out_instr, 32'h123452B7);
    chk("li1_count", 32'(count), 32'd1);
    chk("li1_ready", 32'(in_ready), 32'd1);
    drain();

    // Branch legal and odd offset, store with bad funct3.
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8);
    chk("beq_head", out_instr, 32'h00208463);
    drain();
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd7);
    chk("beq_odd_count", 32'(count), 32'd0);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd3, 1'b0, 32'd0);
    @(negedge clk);
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("err_code_held", 32'(err_code), 32'd2);

    // Fill the FIFO, then a single pop reopens in_ready.
    for (int i = 1; i <= 4; i++) send(3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
    chk("full_count", 32'(count), 32'd4);
    chk("full_not_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk("pop1_count", 32'(count), 32'd3);
    chk("pop1_ready", 32'(in_ready), 32'd1);
    drain();

    // LI word2 waits in EMIT2 for space.
    for (int i = 1; i <= 3; i++) send(3'd0, 5'(i), 5'd0, 5'd0, 3'd4, 1'b0, 32'(i + 16));
    send(3'd7, 5'd6, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE123);
    chk("emit2_count", 32'(count), 32'd4);
    chk("emit2_not_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("emit2_hold_count", 32'(count), 32'd4);
    chk("emit2_hold_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    @(negedge clk);
    chk("emit2_pop_count", 32'(count), 32'd3);
    @(negedge clk);
    chk("emit2_push_count", 32'(count), 32'd4);
    chk("emit2_full_ready", 32'(in_ready), 32'd0);
    drain();

    // Flush while parked in EMIT2 with a full FIFO.
    for (int i = 1; i <= 3; i++) send(3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
    send(3'd7, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00012345);
    chk("fl_pre_count", 32'(count), 32'd4);
    chk("fl_pre_err_code", 32'(err_code), 32'd2);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1; flush = 1'b0; exp_q.delete(); out_ready = 1'b1;
    @(negedge clk);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_out_instr", out_instr, 32'd0);
    chk("fl_err_code", 32'(err_code), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("fl_no_word2", 32'(out_valid), 32'd0);
    @(posedge clk); #1; out_ready = 1'b0;

    // Same situation cleared by reset instead.
    for (int i = 1; i <= 3; i++) send(3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 1'b0, 32'(i));
    send(3'd7, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00012345);
    chk("rs_pre_count", 32'(count), 32'd4);
    @(posedge clk); #1; resetn = 1'b0;
    @(negedge clk);
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1; resetn = 1'b1; exp_q.delete(); out_ready = 1'b1;
    @(negedge clk);
    chk("rs_count", 32'(count), 32'd0);
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    repeat (4) @(negedge clk);
    chk("rs_no_word2", 32'(out_valid), 32'd0);

    // Boundary mix streamed with the consumer always ready.
    send(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFF800);
    send(3'd7, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
    send(3'd0, 5'd2, 5'd3, 5'd0, 3'd5, 1'b1, 32'd31);
    send(3'd0, 5'd2, 5'd3, 5'd0, 3'd1, 1'b0, 32'd32);
    send(3'd0, 5'd2, 5'd3, 5'd0, 3'd1, 1'b1, 32'd3);
    send(3'd0, 5'd2, 5'd3, 5'd0, 3'd0, 1'b0, 32'hFFFFF800);
    send(3'd2, 5'd4, 5'd1, 5'd0, 3'd4, 1'b0, 32'd2047);
    send(3'd2, 5'd4, 5'd1, 5'd0, 3'd0, 1'b0, 32'd2048);
    send(3'd3, 5'd0, 5'd2, 5'd9, 3'd2, 1'b0, 32'hFFFFF801);
    send(3'd4, 5'd0, 5'd3, 5'd4, 3'd7, 1'b0, 32'hFFFFF000);
    send(3'd4, 5'd0, 5'd3, 5'd4, 3'd1, 1'b0, 32'd4096);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048574);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFF00000);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd1048576);
    send(3'd6, 5'd8, 5'd0, 5'd0, 3'd0, 1'b0, 32'hDEAD0000);
    send(3'd6, 5'd8, 5'd0, 5'd0, 3'd0, 1'b0, 32'hDEAD0001);
    send(3'd1, 5'd9, 5'd1, 5'd2, 3'd5, 1'b1, 32'd0);
    send(3'd1, 5'd9, 5'd1, 5'd2, 3'd4, 1'b1, 32'd0);
    drain();
    chk("model_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
